// File: rtl/mem_io_ctrl.sv
// rtl/mem_io_ctrl.sv - eLC-3 memory/I-O access controller with SRAM wait states
//
// Purpose:
//   Bridges the eLC-3 datapath memory request (MAR/MDR, MIO_EN, R_W) to an
//   external synchronous SRAM with WAIT_CYCLES extra access cycles, or to
//   a small on-chip I/O region at IO_BASE and above. Completion is signalled
//   by a one-cycle R pulse.
//
//   I/O map, by offset from IO_BASE:
//     0   In_Port  (switches, read-only)
//     1   Out_Port (LEDs, read/write)
//     2   free-running cycle counter (read-only)
//     3+  reads 0, writes ignored
//
// Ports:
//   Clk, Reset            clock (rising edge), async active-low reset
//   MIO_EN, R_W           request (held until R) and direction (1 = write)
//   MAR, MDR_In           access address and write data
//   Mem_Out, R            registered read data and ready pulse
//   Mem_Addr, Mem_WData   registered SRAM address and write data
//   Mem_RData             SRAM read data
//   Mem_CE, Mem_WE        SRAM chip enable and write enable (ACCESS only)
//   In_Port, Out_Port     switch input and LED output register
module mem_io_ctrl #(
  parameter int                  DATA_W      = 16,
  parameter int                  ADDR_W      = 16,
  parameter int                  WAIT_CYCLES = 2,
  parameter logic [ADDR_W-1:0]   IO_BASE     = 16'hFE00
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              MIO_EN,
  input  logic              R_W,
  input  logic [ADDR_W-1:0] MAR,
  input  logic [DATA_W-1:0] MDR_In,
  output logic [DATA_W-1:0] Mem_Out,
  output logic              R,
  output logic [ADDR_W-1:0] Mem_Addr,
  output logic [DATA_W-1:0] Mem_WData,
  input  logic [DATA_W-1:0] Mem_RData,
  output logic              Mem_CE,
  output logic              Mem_WE,
  input  logic [DATA_W-1:0] In_Port,
  output logic [DATA_W-1:0] Out_Port
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    DONE    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t            state;
  logic [3:0]        wait_cnt;
  logic              wr_q;
  logic [DATA_W-1:0] cyc_cnt;
  logic [ADDR_W-1:0] io_off;
  logic [DATA_W-1:0] io_rdata;

  assign io_off = MAR - IO_BASE;

  // Read mux for the I/O region; unmapped offsets read as zero.
  always_comb begin
    io_rdata = '0;
    if (io_off == ADDR_W'(0))
      io_rdata = In_Port;
    else if (io_off == ADDR_W'(1))
      io_rdata = Out_Port;
    else if (io_off == ADDR_W'(2))
      io_rdata = cyc_cnt;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state     <= IDLE;
      wait_cnt  <= 4'd0;
      wr_q      <= 1'b0;
      cyc_cnt   <= '0;
      Mem_Out   <= '0;
      R         <= 1'b0;
      Mem_Addr  <= '0;
      Mem_WData <= '0;
      Mem_CE    <= 1'b0;
      Mem_WE    <= 1'b0;
      Out_Port  <= '0;
    end else begin
      cyc_cnt <= cyc_cnt + DATA_W'(1);
      R       <= 1'b0;
      case (state)
        IDLE: begin
          if (MIO_EN) begin
            wr_q <= R_W;
            if (MAR < IO_BASE) begin
              Mem_Addr  <= MAR;
              Mem_WData <= MDR_In;
              Mem_CE    <= 1'b1;
              Mem_WE    <= R_W;
              wait_cnt  <= 4'd0;
              state     <= ACCESS;
            end else begin
              // I/O accesses complete at the sampling edge itself.
              if (!R_W)
                Mem_Out <= io_rdata;
              else if (io_off == ADDR_W'(1))
                Out_Port <= MDR_In;
              R     <= 1'b1;
              state <= DONE;
            end
          end
        end
        ACCESS: begin
          // Request inputs are ignored here; everything was latched in IDLE.
          if (wait_cnt == 4'(WAIT_CYCLES)) begin
            if (!wr_q)
              Mem_Out <= Mem_RData;
            Mem_CE <= 1'b0;
            Mem_WE <= 1'b0;
            R      <= 1'b1;
            state  <= DONE;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        DONE: begin
          state <= MIO_EN ? RELEASE : IDLE;
        end
        RELEASE: begin
          // Wait for the FSM to drop its request so a held MIO_EN cannot retrigger.
          if (!MIO_EN)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_io_ctrl.md
Name: mem_io_ctrl

Overview:
- Parametrised memory/I-O access controller between the eLC-3 datapath (MAR/MDR, MIO_EN, R_W) and external synchronous SRAM plus a small memory-mapped I/O region.
- Adds to the fixed single-cycle memory path:
  - configurable data/address width;
  - configurable SRAM wait states with a ready (R) handshake for the control FSM;
  - address decode into SRAM vs. on-chip I/O registers: switch input, LED output, free-running cycle counter.

Parameters:
DATA_W, 16, data word width
ADDR_W, 16, address width
WAIT_CYCLES, 2, extra SRAM access cycles (0..15)
IO_BASE, 16'hFE00, addresses >= IO_BASE decode to I/O region (ADDR_W bits)

Ports:
Clk  in  1  system clock, all state on rising edge
Reset  in  1  asynchronous, active-low reset
MIO_EN  in  1  access request from control FSM, held high until R seen
R_W  in  1  1 = write, 0 = read; sampled with MIO_EN
MAR  in  ADDR_W  access address
MDR_In  in  DATA_W  write data
Mem_Out  out  DATA_W  read data to MDR, registered
R  out  1  ready, one-cycle pulse on completion
Mem_Addr  out  ADDR_W  SRAM address, registered
Mem_WData  out  DATA_W  SRAM write data, registered
Mem_RData  in  DATA_W  SRAM read data
Mem_CE  out  1  SRAM chip enable
Mem_WE  out  1  SRAM write enable
In_Port  in  DATA_W  switch input (I/O offset 0, read-only)
Out_Port  out  DATA_W  LED register (I/O offset 1, R/W)

Behaviour:
- Reset (async, Reset=0), all held until Reset=1:
  - State IDLE; wait counter 0.
  - Mem_Out, R, Mem_Addr, Mem_WData, Mem_CE, Mem_WE, Out_Port, cycle counter = 0.
- Cycle counter (I/O offset 2):
  - DATA_W bits, increments every cycle out of reset, wraps all-ones -> 0.
  - Read-only; writes to offset 2 are ignored.
  - I/O offsets >= 3 read 0; writes to them are ignored.
- FSM states: IDLE, ACCESS, DONE, RELEASE.
- IDLE, MIO_EN=1 at edge: latch MAR, MDR_In, R_W.
  - SRAM region (MAR < IO_BASE): Mem_Addr <= MAR, Mem_WData <= MDR_In, Mem_CE <= 1, Mem_WE <= R_W; counter <= 0; go ACCESS.
  - I/O region: perform the access at this edge, go DONE.
    - Read: Mem_Out <= register value.
    - Write: Out_Port <= MDR_In for offset 1.
- ACCESS: counter increments each cycle.
  - When counter == WAIT_CYCLES: if read, Mem_Out <= Mem_RData; Mem_CE, Mem_WE <= 0; go DONE.
  - ACCESS lasts exactly WAIT_CYCLES+1 cycles; Mem_Addr/Mem_WData stable throughout.
  - MIO_EN/MAR changes during ACCESS are ignored.
- DONE: R=1 for exactly this cycle. Next state RELEASE if MIO_EN=1, else IDLE.
- RELEASE: R=0; go IDLE when MIO_EN=0. Prevents retrigger on a held request.
- Latency (cycle 0 = edge MIO_EN sampled in IDLE):
  - SRAM: R high in cycle WAIT_CYCLES+2.
  - I/O: R high in cycle 1.
  - Mem_Out valid when R is high; holds until the next read completes. Writes leave Mem_Out unchanged.
- Out_Port changes only on an I/O write to offset 1.
- Reset asserted mid-ACCESS: Mem_CE/Mem_WE drop immediately (async); no R pulse; access abandoned.
- Mem_CE=0 and Mem_WE=0 in every state except ACCESS.

Test Plan:
- Reset, WAIT_CYCLES=2, read MAR=16'h3000 with SRAM model returning 16'hBEEF:
  - Mem_CE high 3 cycles, Mem_WE low.
  - R pulses 1 cycle in cycle 4.
  - Mem_Out=16'hBEEF.
- Write MAR=16'h3001, MDR_In=16'h1234:
  - Mem_WE=Mem_CE=1 for 3 cycles; Mem_Addr=16'h3001; Mem_WData=16'h1234.
  - R in cycle 4; Mem_Out unchanged.
- I/O:
  - Write MAR=16'hFE01, MDR_In=16'h00A5: Out_Port=16'h00A5 and R in cycle 1; Mem_CE never asserted.
  - Then read MAR=16'hFE00 with In_Port=16'h3C3C: Mem_Out=16'h3C3C.
- MIO_EN held high 10 cycles after a read: exactly one R pulse, one SRAM access.
  - Drop MIO_EN, reassert: second access proceeds normally.
- Read 16'hFE02 twice, 5 cycles apart: values differ by the number of cycles between the two sampling edges.
  - Read 16'hFE07: Mem_Out=0.
- Reset pulsed low during cycle 2 of an SRAM write:
  - Mem_CE/Mem_WE drop immediately; state IDLE; no R.
  - Out_Port=0, counter restarts from 0.
